if_ctrl: RTL and testbench
==========================

Name: if_ctrl

Overview:
Instruction-fetch sequencer that feeds the decode stage. It owns the fetch PC and issues one-outstanding word requests to instruction memory over a req/ack handshake. Returned words go into a small FIFO presented to the decoder with valid/ready. Branch/jump redirects flush the FIFO and discard any in-flight fetch.

Parameters:
XLEN, 32, datapath and address width.
RESET_PC, 32'h0000_0000, first fetch address after reset.
DEPTH, 2, FIFO entries (power of two, >=2).

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
imem_req  out  1  fetch request.
imem_addr  out  XLEN  fetch word address, low 2 bits always 0.
imem_ack  in  1  request complete, imem_rdata valid this cycle.
imem_rdata  in  XLEN  fetched word.
redirect  in  1  PC redirect (branch/jump/trap), one-cycle pulse or level.
redirect_pc  in  XLEN  redirect target, low 2 bits ignored (forced 0).
inst_valid  out  1  FIFO head valid.
inst  out  XLEN  FIFO head instruction, 32'h0000_0013 (NOP) when !inst_valid.
inst_pc  out  XLEN  PC of FIFO head, 0 when !inst_valid.
inst_ready  in  1  decoder accepts head.

Behaviour:
- Reset (rst sampled high at edge): pc=RESET_PC, FIFO count=0, state=FETCH. While rst is high, imem_req=0 and inst_valid=0. imem_addr=RESET_PC, inst=NOP, inst_pc=0. An in-flight memory request is abandoned; the memory side must tolerate this.
- State FETCH:
  - imem_req = (count < DEPTH); imem_addr = pc.
  - Transaction completes in any cycle with imem_req && imem_ack, including the first req cycle (zero-wait).
  - On completion: push {pc, imem_rdata}; pc <= pc+4 (wraps modulo 2^XLEN).
- Request stability: once imem_req rises, it and imem_addr stay constant until ack. Count cannot rise while a request is outstanding, so the space condition cannot drop mid-transaction.
- FIFO:
  - inst_valid = (count != 0). Pop when inst_valid && inst_ready.
  - Push and pop may occur in the same cycle; count is unchanged.
  - No overflow by construction.
  - Throughput with zero-wait ack and inst_ready=1: one instruction per cycle.
- Redirect has priority over everything except rst. In a cycle with redirect=1:
  - FIFO flushed (count<=0); any same-cycle pop is treated as accepted by the decoder, and a same-cycle push is dropped.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - If a request is outstanding and not acked this cycle: save the old address in drop_addr and go to DROP. Otherwise stay in FETCH.
  - inst_valid=0 in the following cycle.
- State DROP:
  - imem_req=1, imem_addr=drop_addr (held).
  - On ack: discard data, no push, no pc increment, go to FETCH. The next request uses the redirected pc in the following cycle.
  - A further redirect in DROP updates pc only; state stays DROP.
- Latency: redirect to new-target imem_req is 1 cycle, or ack+1 if in DROP. Ack to inst_valid is 1 cycle.

Test Plan:
- Release rst, imem_ack tied 1, imem_rdata=addr^32'hA5A5_0000, inst_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; inst_valid from 2nd cycle with inst_pc 0,4,8 and matching inst, one per cycle.
- inst_ready=0 after reset, zero-wait ack -> two pushes (pc 0,4), then imem_req=0 and inst_pc held at 0. Raise inst_ready -> pops 0,4, then fetch resumes at 8, in order, no loss or duplicates.
- Ack latency 3 cycles -> imem_req=1 and imem_addr=0 stable for 3 cycles; inst_valid rises one cycle after ack.
- Fetch of 0x8 outstanding, redirect with redirect_pc=0x103, ack 2 cycles later -> imem_addr stays 0x8 until ack; the 0x8 data never appears on inst; next request addr 0x100; first inst_pc=0x100.
- FIFO full (0x0, 0x4), redirect in the same cycle as a completing ack of 0x8 with target 0x200 -> next cycle inst_valid=0, imem_addr=0x200, state FETCH (no DROP).
- rst asserted while in DROP -> imem_req=0 while rst is high; after release imem_addr=RESET_PC, count 0; the stale ack is not pushed.

Source files
------------

// File: rtl/if_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one-outstanding word
// requests to instruction memory and buffers returned words in a small FIFO
// presented to decode. Redirects flush the FIFO and discard in-flight fetches.
module if_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  localparam int unsigned     PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] Nop  = XLEN'(32'h0000_0013);

  typedef enum logic [0:0] {StFetch, StDrop} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   drop_addr_q, drop_addr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]   fifo_pc_q [DEPTH];
  logic [XLEN-1:0]   fifo_pc_d [DEPTH];
  logic [XLEN-1:0]   fifo_data_q [DEPTH];
  logic [XLEN-1:0]   fifo_data_d [DEPTH];

  logic            has_space;
  logic            req_int;
  logic            xfer;
  logic            push;
  logic            pop;
  logic            unused_pc_bits;

  // Low two bits of the redirect target are architecturally ignored.
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Request, FIFO head and handshake decode; rst forces idle outputs.
  always_comb begin
    has_space  = count_q < CntW'(DEPTH);
    req_int    = (state_q == StDrop) || has_space;
    imem_req   = !rst && req_int;
    if (rst) begin
      imem_addr = RESET_PC;
    end else if (state_q == StDrop) begin
      imem_addr = drop_addr_q;
    end else begin
      imem_addr = pc_q;
    end
    xfer       = imem_req && imem_ack;
    inst_valid = !rst && (count_q != '0);
    inst       = inst_valid ? fifo_data_q[rd_ptr_q] : Nop;
    inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
    pop        = inst_valid && inst_ready;
    // Data returned for a dropped address, or during a redirect, is discarded.
    push       = xfer && (state_q == StFetch) && !redirect;
  end

  // Next-state for PC, FSM, FIFO pointers/count and storage.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_data_d = fifo_data_q;

    unique case (state_q)
      StFetch: if (xfer) pc_d = pc_q + XLEN'(4);
      StDrop:  if (xfer) state_d = StFetch;
      default: state_d = StFetch;
    endcase

    if (push) begin
      fifo_pc_d[wr_ptr_q]   = pc_q;
      fifo_data_d[wr_ptr_q] = imem_rdata;
    end

    if (redirect) begin
      pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // An unacked request cannot be withdrawn; remember it and swallow its ack.
      if ((state_q == StFetch) && req_int && !imem_ack) begin
        state_d     = StDrop;
        drop_addr_d = pc_q;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_if_ctrl.sv
// Self-checking bench for if_ctrl: directed scenarios with a queue scoreboard
// of expected {pc, instruction} pairs for delivered instructions.
module tb_if_ctrl;

  localparam logic [31:0] Key = 32'hA5A5_0000;
  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  if_ctrl #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns a word derived from the address being fetched.
  always_comb imem_rdata = imem_addr ^ Key;

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic r, input logic ack, input logic rdy, input logic rd,
                       input logic [31:0] rpc);
    @(negedge clk);
    rst = r; imem_ack = ack; inst_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    sb.delete();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0055);
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== Nop || inst_pc !== 32'h0 ||
          imem_addr !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: req=%b valid=%b inst=%h pc=%h addr=%h, want 0 0 %h 0 0",
                 imem_req, inst_valid, inst, inst_pc, imem_addr, Nop);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req=%b addr=%h valid=%b, want 1 0 0",
               imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic [63:0] e;
    do_reset();
    exp_pc = 32'h0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL stream_addr: req=%b addr=%h, want 1 %h", imem_req, imem_addr, exp_pc);
      end
      checks++;
      if (inst_valid !== (k != 0)) begin
        errors++;
        $display("FAIL stream_valid: cycle %0d valid=%b, want %b", k, inst_valid, k != 0);
      end
      if (inst_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stream_sb_empty: got pc=%h inst=%h with nothing expected", inst_pc, inst);
        end else begin
          e = sb.pop_front();
          if ({inst_pc, inst} !== e) begin
            errors++;
            $display("FAIL stream_data: pc=%h inst=%h, want pc=%h inst=%h",
                     inst_pc, inst, e[63:32], e[31:0]);
          end
        end
      end
      sb.push_back({exp_pc, exp_pc ^ Key});
      exp_pc += 32'd4;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    logic [63:0] e;
    int          mcount;
    logic        rdy;
    logic        exp_req;
    do_reset();
    exp_pc = 32'h0;
    mcount = 0;
    for (int k = 0; k < 12; k++) begin
      rdy = (k >= 4);
      drive(1'b0, 1'b1, rdy, 1'b0, 32'h0);
      exp_req = (mcount < 2);
      checks++;
      if (imem_req !== exp_req || (exp_req && imem_addr !== exp_pc)) begin
        errors++;
        $display("FAIL bp_req: cycle %0d req=%b addr=%h, want %b %h",
                 k, imem_req, imem_addr, exp_req, exp_pc);
      end
      checks++;
      if (inst_valid !== (mcount != 0)) begin
        errors++;
        $display("FAIL bp_valid: cycle %0d valid=%b, want %b", k, inst_valid, mcount != 0);
      end
      if (k == 2 || k == 3) begin
        checks++;
        if (inst_pc !== 32'h0) begin
          errors++;
          $display("FAIL bp_hold: inst_pc=%h, want 0", inst_pc);
        end
      end
      if (inst_valid === 1'b1 && rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_sb_empty: got pc=%h inst=%h with nothing expected", inst_pc, inst);
        end else begin
          e = sb.pop_front();
          if ({inst_pc, inst} !== e) begin
            errors++;
            $display("FAIL bp_data: pc=%h inst=%h, want pc=%h inst=%h",
                     inst_pc, inst, e[63:32], e[31:0]);
          end
        end
        mcount--;
      end
      if (exp_req) begin
        sb.push_back({exp_pc, exp_pc ^ Key});
        exp_pc += 32'd4;
        mcount++;
      end
    end
  endtask

  task automatic test_ack_latency();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k == 2, 1'b1, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL lat_hold: cycle %0d req=%b addr=%h valid=%b, want 1 0 0",
                 k, imem_req, imem_addr, inst_valid);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== Key || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL lat_deliver: valid=%b pc=%h inst=%h addr=%h, want 1 0 %h 4",
               inst_valid, inst_pc, inst, imem_addr, Key);
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_pc !== 32'h4) begin
      errors++;
      $display("FAIL drop_start: req=%b addr=%h pc=%h, want 1 8 4", imem_req, imem_addr, inst_pc);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_hold: req=%b addr=%h valid=%b, want 1 8 0",
               imem_req, imem_addr, inst_valid);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL drop_ack_addr: addr=%h, want 8", imem_addr);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_new_req: req=%b addr=%h valid=%b, want 1 100 0",
               imem_req, imem_addr, inst_valid);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== (32'h100 ^ Key)) begin
      errors++;
      $display("FAIL drop_first_inst: valid=%b pc=%h inst=%h, want 1 100 %h",
               inst_valid, inst_pc, inst, 32'h100 ^ Key);
    end
  endtask

  task automatic test_redirect_on_ack();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL full_stall: req=%b valid=%b pc=%h, want 0 1 0", imem_req, inst_valid, inst_pc);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b0 || inst_pc !== 32'h0 || inst !== Key) begin
      errors++;
      $display("FAIL full_pop: req=%b pc=%h inst=%h, want 0 0 %h", imem_req, inst_pc, inst, Key);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_pc !== 32'h4) begin
      errors++;
      $display("FAIL ackredir_req: req=%b addr=%h pc=%h, want 1 8 4", imem_req, imem_addr, inst_pc);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
        errors++;
        $display("FAIL ackredir_after: cycle %0d valid=%b req=%b addr=%h, want 0 1 200",
                 k, inst_valid, imem_req, imem_addr);
      end
    end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0040);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rdrop_in_drop: req=%b addr=%h, want 1 0", imem_req, imem_addr);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rdrop_rst: req=%b valid=%b addr=%h, want 0 0 0",
               imem_req, inst_valid, imem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL rdrop_release: cycle %0d req=%b addr=%h valid=%b, want 1 0 0",
                 k, imem_req, imem_addr, inst_valid);
      end
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== Key || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL rdrop_refetch: valid=%b pc=%h inst=%h addr=%h, want 1 0 %h 4",
               inst_valid, inst_pc, inst, imem_addr, Key);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_ack_latency();
    test_redirect_drop();
    test_redirect_on_ack();
    test_reset_in_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
